// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM bank test engines: FSM states, LFSR
// polynomial and mode encodings.
package jtsdram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    DONE
  } state_t;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] SEED_ZERO_SUB = 16'h0001;

  localparam logic MODE_RD = 1'b0;
  localparam logic MODE_WR = 1'b1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/jtsdram_lfsr16.sv
// 16-bit Fibonacci LFSR pattern source with seed load and single-step advance.
module jtsdram_lfsr16
  import jtsdram_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  // An all-zero state would lock the LFSR, so a zero seed is substituted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         value <= '0;
    else if (load)    value <= (seed == '0) ? SEED_ZERO_SUB : seed;
    else if (advance) value <= lfsr_next(value);
  end

endmodule

// File: rtl/jtsdram_rwbank.sv
// Per-bank SDRAM test engine: optional LFSR write pass, then a read pass that
// compares against the same sequence, with error capture and a watchdog.
module jtsdram_rwbank
  import jtsdram_pkg::*;
#(
  parameter int AW   = 22,
  parameter int DW   = 16,
  parameter int CW   = 8,
  parameter int TOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  input  logic [15:0]     seed,
  input  logic [AW-1:0]   last_addr,
  input  logic            hold,
  output logic [AW-1:0]   addr,
  output logic            rd,
  output logic            wr,
  output logic [DW-1:0]   din,
  output logic [DW/8-1:0] din_m,
  input  logic            ack,
  input  logic            rdy,
  input  logic [31:0]     data_read,
  output logic            busy,
  output logic            done,
  output logic            bad,
  output logic            timeout,
  output logic [CW-1:0]   err_cnt,
  output logic [AW-1:0]   fail_addr,
  output logic [DW-1:0]   fail_data
);

  localparam int WDW = $clog2(TOUT + 1);

  state_t          state, state_d;
  logic [AW-1:0]   addr_d, last_q, last_d, fail_addr_d;
  logic [15:0]     seed_q, seed_d, lfsr_seed, lfsr;
  logic            req, req_d, bad_d, timeout_d;
  logic [WDW-1:0]  wd_cnt, wd_d;
  logic [CW-1:0]   err_d;
  logic [DW-1:0]   fail_data_d, expected;
  logic            lfsr_load, lfsr_adv, complete;
  logic            is_wr, at_last, mismatch, waiting, wd_expired;

  // Phase restarts reuse the seed captured at start; a fresh start takes the port.
  assign lfsr_seed = (state == IDLE || state == DONE) ? seed : seed_q;

  jtsdram_lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (lfsr_seed),
    .advance (lfsr_adv),
    .value   (lfsr)
  );

  generate
    if (DW == 32) begin : g_dw32
      assign expected = {lfsr, ~lfsr};
    end else begin : g_dw16
      logic unused_hi;
      assign expected  = lfsr;
      assign unused_hi = ^data_read[31:16];
    end
  endgenerate

  assign busy     = !(state == IDLE || state == DONE);
  assign done     = (state == DONE);
  assign rd       = req && (state == RD_REQ);
  assign wr       = req && (state == WR_REQ);
  assign din      = wr ? expected : '0;
  assign din_m    = '0;
  assign is_wr    = (state == WR_REQ || state == WR_WAIT);
  assign at_last  = (addr == last_q);
  assign mismatch = (data_read[DW-1:0] != expected);
  assign waiting  = (state == WR_WAIT || state == RD_WAIT);
  assign wd_expired = (req || waiting) && !rdy && (wd_cnt == WDW'(TOUT - 1));

  // NOTE: every signal gets its hold value before the case so no path infers a latch.
  always_comb begin
    state_d     = state;
    addr_d      = addr;
    req_d       = req;
    wd_d        = wd_cnt;
    last_d      = last_q;
    seed_d      = seed_q;
    bad_d       = bad;
    timeout_d   = timeout;
    err_d       = err_cnt;
    fail_addr_d = fail_addr;
    fail_data_d = fail_data;
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;
    complete    = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d     = (mode == MODE_WR) ? WR_REQ : RD_REQ;
          addr_d      = '0;
          last_d      = last_addr;
          seed_d      = seed;
          bad_d       = 1'b0;
          timeout_d   = 1'b0;
          err_d       = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          lfsr_load   = 1'b1;
        end
      end
      WR_REQ, RD_REQ: begin
        // hold only blocks raising a request; a raised one runs to ack.
        if (!req) begin
          if (!hold) begin
            req_d = 1'b1;
            wd_d  = '0;
          end
        end else begin
          wd_d = wd_cnt + WDW'(1);
          if (ack) begin
            req_d = 1'b0;
            if (rdy) complete = 1'b1;
            else     state_d  = (state == WR_REQ) ? WR_WAIT : RD_WAIT;
          end
        end
      end
      WR_WAIT, RD_WAIT: begin
        wd_d = wd_cnt + WDW'(1);
        if (rdy) complete = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      if (!is_wr && mismatch) begin
        bad_d = 1'b1;
        if (err_cnt != '1) err_d = err_cnt + CW'(1);
        if (err_cnt == '0) begin
          fail_addr_d = addr;
          fail_data_d = data_read[DW-1:0];
        end
      end
      if (at_last) begin
        if (is_wr) begin
          addr_d    = '0;
          lfsr_load = 1'b1;
          state_d   = RD_REQ;
        end else begin
          state_d = DONE;
        end
      end else begin
        addr_d   = addr + AW'(1);
        lfsr_adv = 1'b1;
        state_d  = is_wr ? WR_REQ : RD_REQ;
      end
    end

    if (wd_expired) begin
      timeout_d = 1'b1;
      bad_d     = 1'b1;
      req_d     = 1'b0;
      state_d   = DONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr      <= '0;
      last_q    <= '0;
      seed_q    <= '0;
      req       <= 1'b0;
      wd_cnt    <= '0;
      bad       <= 1'b0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state     <= state_d;
      addr      <= addr_d;
      last_q    <= last_d;
      seed_q    <= seed_d;
      req       <= req_d;
      wd_cnt    <= wd_d;
      bad       <= bad_d;
      timeout   <= timeout_d;
      err_cnt   <= err_d;
      fail_addr <= fail_addr_d;
      fail_data <= fail_data_d;
    end
  end

endmodule

// File: tb/tb_jtsdram_rwbank.sv
// Directed bench for jtsdram_rwbank with a small SDRAM responder model.
module tb_jtsdram_rwbank;

  localparam int AW = 22, DW = 16, CW = 8, TOUT = 1023;

  logic            clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0, hold = 1'b0;
  logic            ack = 1'b0, rdy = 1'b0;
  logic [15:0]     seed = '0;
  logic [AW-1:0]   last_addr = '0;
  logic [31:0]     data_read = '0;
  logic [AW-1:0]   addr, fail_addr;
  logic            rd, wr, busy, done, bad, timeout;
  logic [DW-1:0]   din, fail_data;
  logic [DW/8-1:0] din_m;
  logic [CW-1:0]   err_cnt;

  int tests_run = 0, tests_failed = 0;

  jtsdram_rwbank #(.AW(AW), .DW(DW), .CW(CW), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .last_addr(last_addr), .hold(hold), .addr(addr), .rd(rd), .wr(wr),
    .din(din), .din_m(din_m), .ack(ack), .rdy(rdy), .data_read(data_read),
    .busy(busy), .done(done), .bad(bad), .timeout(timeout), .err_cnt(err_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  // Responder: ack one cycle after a request appears, rdy the cycle after,
  // or both at once when same_cycle is set.
  bit            no_rdy = 0, same_cycle = 0, corrupt_en = 0, mask_seen = 0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [15:0]   mem [16];
  logic [AW-1:0] wr_addr_q[$], rd_addr_q[$];
  logic [15:0]   wr_data_q[$];
  bit            pend = 0;
  logic [15:0]   pend_data = '0;

  initial begin : model
    forever begin
      @(posedge clk); #1;
      ack = 1'b0;
      rdy = 1'b0;
      if (!rst) begin
        pend = 0;
      end else if (pend) begin
        pend = 0;
        if (!no_rdy) begin
          rdy = 1'b1;
          data_read = {16'hA5A5, pend_data};
        end
      end else if (rd || wr) begin
        ack = 1'b1;
        if (wr) begin
          mem[addr[3:0]] = din;
          wr_addr_q.push_back(addr);
          wr_data_q.push_back(din);
          if (din_m != '0) mask_seen = 1;
          pend_data = 16'h0000;
        end else begin
          rd_addr_q.push_back(addr);
          pend_data = (corrupt_en && addr == corrupt_addr) ? 16'h00FF : mem[addr[3:0]];
        end
        if (same_cycle) begin
          if (!no_rdy) begin
            rdy = 1'b1;
            data_read = {16'hA5A5, pend_data};
          end
        end else begin
          pend = 1;
        end
      end
    end
  end

  task automatic start_run(input logic m, input logic [15:0] s, input logic [AW-1:0] la);
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    @(posedge clk); #1;
    mode = m; seed = s; last_addr = la; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit expired);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    expired = (done !== 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, bad, timeout, rd, wr} !== 6'b0 || addr !== '0 || din !== '0 || din_m !== '0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/done/bad/tout/rd/wr=%b addr=%0h din=%h, need all 0",
               {busy, done, bad, timeout, rd, wr}, addr, din);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (err_cnt !== '0 || fail_addr !== '0 || fail_data !== '0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_regs: err=%0d fail_addr=%0h fail_data=%h busy=%b, need 0",
               err_cnt, fail_addr, fail_data, busy);
    end
  endtask

  task automatic test_write_read();
    bit exp;
    logic [15:0] want [3] = '{16'h0001, 16'h0002, 16'h0004};
    start_run(1'b1, 16'h0001, AW'(2));
    wait_done(200, exp);
    tests_run++;
    if (exp) begin tests_failed++; $display("FAIL write_read_done: done=%b, need 1", done); end
    tests_run++;
    if (wr_data_q.size() != 3 || rd_addr_q.size() != 3) begin
      tests_failed++;
      $display("FAIL write_read_count: writes=%0d reads=%0d, need 3/3", wr_data_q.size(), rd_addr_q.size());
    end
    for (int i = 0; i < 3 && i < wr_data_q.size(); i++) begin
      tests_run++;
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== want[i]) begin
        tests_failed++;
        $display("FAIL write_read_wr%0d: addr=%0h data=%h, need addr=%0h data=%h",
                 i, wr_addr_q[i], wr_data_q[i], i, want[i]);
      end
    end
    tests_run++;
    if (bad !== 1'b0 || err_cnt !== '0 || busy !== 1'b0 || timeout !== 1'b0 || mask_seen) begin
      tests_failed++;
      $display("FAIL write_read_status: bad=%b err=%0d busy=%b tout=%b mask=%b, need 0",
               bad, err_cnt, busy, timeout, mask_seen);
    end
  endtask

  task automatic test_mismatch();
    bit exp;
    corrupt_en = 1; corrupt_addr = AW'(1);
    start_run(1'b1, 16'h0001, AW'(2));
    wait_done(200, exp);
    corrupt_en = 0;
    tests_run++;
    if (exp || bad !== 1'b1 || err_cnt !== CW'(1) || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL mismatch_flags: done=%b bad=%b err=%0d tout=%b, need 1/1/1/0",
               done, bad, err_cnt, timeout);
    end
    tests_run++;
    if (fail_addr !== AW'(1) || fail_data !== 16'h00FF) begin
      tests_failed++;
      $display("FAIL mismatch_capture: addr=%0h data=%h, need 1/00ff", fail_addr, fail_data);
    end
  endtask

  task automatic test_seed_zero();
    bit exp;
    start_run(1'b1, 16'h0000, AW'(0));
    wait_done(100, exp);
    tests_run++;
    if (exp || wr_data_q.size() != 1 || rd_addr_q.size() != 1) begin
      tests_failed++;
      $display("FAIL seed_zero_count: done=%b writes=%0d reads=%0d, need 1/1/1",
               done, wr_data_q.size(), rd_addr_q.size());
    end else begin
      tests_run++;
      if (wr_data_q[0] !== 16'h0001 || wr_addr_q[0] !== '0 || bad !== 1'b0) begin
        tests_failed++;
        $display("FAIL seed_zero_data: data=%h addr=%0h bad=%b, need 0001/0/0",
                 wr_data_q[0], wr_addr_q[0], bad);
      end
    end
  endtask

  task automatic test_hold();
    bit exp;
    int reqs = 0;
    hold = 1'b1;
    start_run(1'b0, 16'h0001, AW'(1));
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (rd || wr) reqs++;
    end
    tests_run++;
    if (reqs != 0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_gate: req cycles=%0d busy=%b, need 0/1", reqs, busy);
    end
    hold = 1'b0;
    wait_done(100, exp);
    tests_run++;
    if (exp || rd_addr_q.size() != 2 || bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_resume: done=%b reads=%0d bad=%b, need 1/2/0", done, rd_addr_q.size(), bad);
    end
  endtask

  task automatic test_same_cycle();
    bit exp;
    same_cycle = 1;
    start_run(1'b0, 16'h0001, AW'(2));
    wait_done(100, exp);
    same_cycle = 0;
    tests_run++;
    if (exp || rd_addr_q.size() != 3 || bad !== 1'b0 || err_cnt !== '0) begin
      tests_failed++;
      $display("FAIL same_cycle_run: done=%b reads=%0d bad=%b err=%0d, need 1/3/0/0",
               done, rd_addr_q.size(), bad, err_cnt);
    end
    for (int i = 0; i < rd_addr_q.size() && i < 3; i++) begin
      tests_run++;
      if (rd_addr_q[i] !== AW'(i)) begin
        tests_failed++;
        $display("FAIL same_cycle_addr%0d: addr=%0h, need %0h", i, rd_addr_q[i], i);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc = 0, rise = -1, fired = -1;
    no_rdy = 1;
    start_run(1'b0, 16'h0001, AW'(3));
    while (fired < 0 && cyc < 1300) begin
      @(posedge clk); #1;
      cyc++;
      if (rd && rise < 0) rise = cyc;
      if (timeout && fired < 0) fired = cyc;
    end
    tests_run++;
    if (fired < 0 || rise < 0 || fired - rise != TOUT) begin
      tests_failed++;
      $display("FAIL timeout_latency: rd at %0d, timeout at %0d, need gap %0d", rise, fired, TOUT);
    end
    tests_run++;
    if ({timeout, bad, done, rd, wr, busy} !== 6'b111000) begin
      tests_failed++;
      $display("FAIL timeout_state: tout/bad/done/rd/wr/busy=%b, need 111000",
               {timeout, bad, done, rd, wr, busy});
    end
  endtask

  task automatic test_reset_mid();
    bit exp;
    int n = 0;
    start_run(1'b0, 16'h0001, AW'(3));
    while (rd !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (rd !== 1'b1) begin tests_failed++; $display("FAIL reset_mid_req: rd=%b, need 1", rd); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, bad, timeout, rd, wr} !== 6'b0 || addr !== '0 || err_cnt !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_clear: busy/done/bad/tout/rd/wr=%b addr=%0h, need 0",
               {busy, done, bad, timeout, rd, wr}, addr);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    no_rdy = 0;
    start_run(1'b1, 16'h0001, AW'(2));
    wait_done(200, exp);
    tests_run++;
    if (exp || wr_data_q.size() != 3 || rd_addr_q.size() != 3 || bad !== 1'b0 || timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_rerun: done=%b writes=%0d reads=%0d bad=%b tout=%b, need 1/3/3/0/0",
               done, wr_data_q.size(), rd_addr_q.size(), bad, timeout);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_mismatch();
    test_seed_zero();
    test_hold();
    test_same_cycle();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
